// File: rtl/cs42448_adc_frame_fifo.sv
// cs42448_adc_frame_fifo: buffers six-channel ADC frames and streams them one channel per beat
module cs42448_adc_frame_fifo #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                      sys_clk,
    input  logic                      sys_rst,
    input  logic                      en,
    input  logic                      sample_stb,
    input  logic [15:0]               adc_l0,
    input  logic [15:0]               adc_r0,
    input  logic [15:0]               adc_l1,
    input  logic [15:0]               adc_r1,
    input  logic [15:0]               adc_l2,
    input  logic [15:0]               adc_r2,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [15:0]               m_data,
    output logic [2:0]                m_chan,
    output logic                      m_last,
    output logic [$clog2(DEPTH):0]    fifo_level,
    output logic                      overflow,
    output logic [CNT_W-1:0]          drop_cnt,
    input  logic                      clr_stat
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    typedef enum logic {IDLE, SEND} state_t;
    typedef logic [5:0][15:0] frame_t;
    frame_t          mem [DEPTH];
    frame_t          head;
    state_t          state;
    logic [2:0]      beat;
    logic [LW-1:0]   wr_ptr, rd_ptr, level_nx;
    logic            full, push, pop, drop;
    // beat presentation from registered state, then FIFO control derived from it
    always_comb begin
        head     = mem[rd_ptr[AW-1:0]];
        m_valid  = state == SEND;
        m_chan   = beat;
        m_last   = m_valid && beat == 3'd5;
        m_data   = m_valid ? head[3'd5 - beat] : '0;
        pop      = m_valid && m_ready && m_last;
        full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        push     = sample_stb && en && (!full || pop);
        drop     = sample_stb && en && full && !pop;
        level_nx = fifo_level + LW'(push) - LW'(pop);
    end
    // frame storage; channel 0 (L0) sits in the top word
    always_ff @(posedge sys_clk)
        if (push) mem[wr_ptr[AW-1:0]] <= {adc_l0, adc_r0, adc_l1, adc_r1, adc_l2, adc_r2};
    // pointers with wrap bit and stored-frame count
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + LW'(1);
            if (pop) rd_ptr <= rd_ptr + LW'(1);
            fifo_level <= level_nx;
        end
    // output FSM; stays in SEND across frames so consecutive frames have no bubble
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            state <= IDLE;
            beat  <= '0;
        end else if (state == IDLE) begin
            if (fifo_level != '0) state <= SEND;
        end else if (m_ready) begin
            beat <= m_last ? 3'd0 : beat + 3'd1;
            if (m_last && level_nx == '0) state <= IDLE;
        end
    // sticky overflow flag and saturating drop counter; clear beats a same-cycle drop
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_stat) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + CNT_W'(1);
        end
endmodule

// File: tb/tb_cs42448_adc_frame_fifo.sv
// tb_cs42448_adc_frame_fifo: scoreboard bench for the ADC frame FIFO
module tb_cs42448_adc_frame_fifo;
    logic        sys_clk, sys_rst, en, sample_stb, m_ready, clr_stat;
    logic [15:0] adc_l0, adc_r0, adc_l1, adc_r1, adc_l2, adc_r2;
    logic        m_valid, m_last, overflow;
    logic [15:0] m_data, drop_cnt;
    logic [2:0]  m_chan, fifo_level;
    logic [19:0] exp_q[$];
    logic [19:0] held, e;
    bit          stall, t4_done;
    int          checks, errors, bub;

    cs42448_adc_frame_fifo #(.DEPTH(4), .CNT_W(16)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .en(en), .sample_stb(sample_stb),
        .adc_l0(adc_l0), .adc_r0(adc_r0), .adc_l1(adc_l1), .adc_r1(adc_r1),
        .adc_l2(adc_l2), .adc_r2(adc_r2), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_chan(m_chan), .m_last(m_last), .fifo_level(fifo_level),
        .overflow(overflow), .drop_cnt(drop_cnt), .clr_stat(clr_stat)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic step;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [95:0] mk(input logic [15:0] b);
        return {b, b + 16'd1, b + 16'd2, b + 16'd3, b + 16'd4, b + 16'd5};
    endfunction

    // f[5] is L0 .. f[0] is R2; exp_push says whether the frame should be accepted
    task automatic strobe(input logic [5:0][15:0] f, input bit exp_push);
        sample_stb = 1'b1;
        {adc_l0, adc_r0, adc_l1, adc_r1, adc_l2, adc_r2} = f;
        if (exp_push)
            for (int c = 0; c < 6; c++) exp_q.push_back({f[5 - c], 3'(c), c == 5});
        step;
        sample_stb = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && (m_valid || fifo_level != 0); i++) step;
        chk(name, {m_valid, 4'(fifo_level)}, 0);
    endtask

    task automatic wait_chan(input string name, input logic [2:0] c);
        for (int i = 0; i < 100 && !(m_valid && m_chan == c); i++) step;
        chk(name, {m_valid, m_chan}, {1'b1, c});
    endtask

    initial begin
        sys_rst = 1'b1; en = 1'b0; sample_stb = 1'b0; m_ready = 1'b0; clr_stat = 1'b0;
        {adc_l0, adc_r0, adc_l1, adc_r1, adc_l2, adc_r2} = '0;
        checks = 0; errors = 0; stall = 0; t4_done = 0;
        fork
            forever begin
                @(negedge sys_clk);
                if (!sys_rst) begin
                    if (stall) begin
                        checks++;
                        if (!m_valid || {m_data, m_chan, m_last} != held) begin
                            errors++;
                            $display("FAIL stall_hold: got v=%0b %0h expected %0h", m_valid, {m_data, m_chan, m_last}, held);
                        end
                    end
                    if (m_valid && m_ready) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL beat: got unexpected %0h expected none", {m_data, m_chan, m_last});
                        end else begin
                            e = exp_q.pop_front();
                            if ({m_data, m_chan, m_last} != e) begin
                                errors++;
                                $display("FAIL beat: got %0h expected %0h", {m_data, m_chan, m_last}, e);
                            end
                        end
                    end
                    stall = m_valid && !m_ready;
                    held  = {m_data, m_chan, m_last};
                end
            end
        join_none
        step; step;
        chk("rst_outputs", {m_valid, m_data, m_chan, m_last, 5'(fifo_level), overflow}, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        sys_rst = 1'b0;
        step;
        // single frame, two-edge latency
        en = 1'b1; m_ready = 1'b1;
        strobe({16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666}, 1);
        chk("t1_level_after_push", {m_valid, 4'(fifo_level)}, {1'b0, 4'd1});
        step;
        chk("t1_first_beat", {m_valid, m_data, m_chan, m_last}, {1'b1, 16'h1111, 3'd0, 1'b0});
        wait_idle("t1_drain");
        // overflow on the fifth frame while stalled, then gap-free drain
        m_ready = 1'b0;
        for (int k = 0; k < 5; k++) strobe(mk(16'h2000 + 16'(k * 16)), k < 4);
        chk("t2_level_full", fifo_level, 4);
        chk("t2_overflow", overflow, 1);
        chk("t2_drop_cnt", drop_cnt, 1);
        m_ready = 1'b1; bub = 0;
        for (int i = 0; i < 24; i++) begin
            if (!m_valid) bub++;
            step;
        end
        chk("t2_bubbles", bub, 0);
        chk("t2_empty_after_24", {m_valid, 4'(fifo_level)}, 0);
        clr_stat = 1'b1; step; clr_stat = 1'b0;
        chk("t2_clear", {overflow, drop_cnt}, 0);
        // push coincident with the last-beat pop while full
        m_ready = 1'b0;
        for (int k = 0; k < 4; k++) strobe(mk(16'h3000 + 16'(k * 16)), 1);
        step;
        chk("t3_level_full", fifo_level, 4);
        m_ready = 1'b1;
        wait_chan("t3_reach_chan5", 3'd5);
        strobe(mk(16'h3F00), 1);
        m_ready = 1'b0;
        chk("t3_level_same", fifo_level, 4);
        chk("t3_no_drop", {overflow, drop_cnt}, 0);
        m_ready = 1'b1;
        wait_idle("t3_drain");
        // random backpressure over 20 frames
        fork
            begin
                for (int k = 0; k < 20; k++) begin
                    for (int i = 0; i < 200 && fifo_level >= 4; i++) step;
                    strobe(mk(16'h4000 + 16'(k * 6)), 1);
                end
                wait_idle("t4_drain");
                t4_done = 1;
            end
            begin
                while (!t4_done) begin
                    step;
                    m_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        chk("t4_no_drop", {overflow, drop_cnt}, 0);
        // capture disabled, then enable dropped mid-frame
        m_ready = 1'b1; en = 1'b0;
        for (int k = 0; k < 3; k++) strobe(mk(16'h5000), 0);
        chk("t5_en_off", {m_valid, 4'(fifo_level), overflow, drop_cnt}, 0);
        en = 1'b1; m_ready = 1'b0;
        strobe(mk(16'h5A00), 1);
        m_ready = 1'b1;
        wait_chan("t5_reach_chan3", 3'd3);
        en = 1'b0;
        wait_idle("t5_drain");
        chk("t5_queue_empty", exp_q.size(), 0);
        // saturation, clear priority, asynchronous reset
        en = 1'b1; m_ready = 1'b0;
        for (int k = 0; k < 4; k++) strobe(mk(16'h6000 + 16'(k * 16)), 1);
        sample_stb = 1'b1;
        repeat (65534) step;
        chk("t6_cnt_fffe", {overflow, drop_cnt}, {1'b1, 16'hFFFE});
        repeat (3) step;
        chk("t6_cnt_sat", {overflow, drop_cnt}, {1'b1, 16'hFFFF});
        clr_stat = 1'b1;
        step;
        sample_stb = 1'b0; clr_stat = 1'b0;
        chk("t6_clear_wins", {overflow, drop_cnt}, 0);
        chk("t6_level_full", fifo_level, 4);
        m_ready = 1'b1;
        wait_chan("t6_reach_chan2", 3'd2);
        #2 sys_rst = 1'b1;
        #1 chk("t6_async_rst", {m_valid, m_data, m_chan, m_last, 4'(fifo_level)}, 0);
        exp_q.delete();
        step;
        sys_rst = 1'b0;
        step; step;
        chk("t6_post_rst", {m_valid, 4'(fifo_level), overflow, drop_cnt}, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
